// File: rtl/mb_read_ctrl.sv
// Macroblock read sequencer: waits for a valid YUV buffer and a ready encoder, streams
// WORDS reads per macroblock, counts the returns and walks the macroblock grid.
module mb_read_ctrl #(
    parameter int HMB   = 80,
    parameter int VMB   = 45,
    parameter int WORDS = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ram_r_valid,
    input  logic       ram_data_valid,
    input  logic       enc_ready,
    output logic       ram_r_ready,
    output logic [6:0] ram_r_addr,
    output logic       mb_start,
    output logic       mb_done,
    output logic       frame_done,
    output logic [6:0] mb_x,
    output logic [5:0] mb_y,
    output logic [6:0] word_idx,
    output logic       busy,
    output logic       stray_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        ISSUE,
        DRAIN,
        WAIT_LOW
    } state_t;

    localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);
    localparam logic [6:0] LAST_X    = 7'(HMB - 1);
    localparam logic [5:0] LAST_Y    = 6'(VMB - 1);

    state_t     state;
    state_t     state_nx;
    logic [6:0] issue_cnt;
    logic [6:0] ret_cnt;

    logic in_xfer;
    logic counting;
    logic mb_fin;
    logic row_end;
    logic frame_end;

    assign in_xfer   = (state == ISSUE) || (state == DRAIN);
    assign counting  = ram_data_valid && in_xfer;
    assign mb_fin    = ram_data_valid && (state == DRAIN) && (ret_cnt == LAST_WORD);
    assign row_end   = (mb_x == LAST_X);
    assign frame_end = row_end && (mb_y == LAST_Y);

    assign ram_r_ready = (state == ISSUE);
    assign ram_r_addr  = ram_r_ready ? issue_cnt : 7'd0;

    // NOTE: state_nx gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (enable) state_nx = WAIT_BUF;
            WAIT_BUF: begin
                if (!enable)                       state_nx = IDLE;
                else if (ram_r_valid && enc_ready) state_nx = ISSUE;
            end
            ISSUE:    if (issue_cnt == LAST_WORD) state_nx = DRAIN;
            DRAIN: begin
                if (mb_fin) begin
                    if (row_end)     state_nx = WAIT_LOW;
                    else if (enable) state_nx = WAIT_BUF;
                    else             state_nx = IDLE;
                end
            end
            // The buffer just consumed is still flagged valid until the RAM releases it.
            WAIT_LOW: if (!ram_r_valid) state_nx = enable ? WAIT_BUF : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= 7'd0;
            ret_cnt    <= 7'd0;
            mb_start   <= 1'b0;
            mb_done    <= 1'b0;
            frame_done <= 1'b0;
            mb_x       <= 7'd0;
            mb_y       <= 6'd0;
            word_idx   <= 7'd0;
            busy       <= 1'b0;
            stray_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            mb_start   <= (state == WAIT_BUF) && (state_nx == ISSUE);
            mb_done    <= mb_fin;
            frame_done <= mb_fin && frame_end;
            busy       <= (state_nx != IDLE);
            issue_cnt  <= (state == ISSUE) ? issue_cnt + 7'd1 : 7'd0;

            if ((state != ISSUE) && (state_nx == ISSUE)) begin
                ret_cnt <= 7'd0;
            end else if (counting) begin
                ret_cnt  <= ret_cnt + 7'd1;
                word_idx <= ret_cnt;
            end

            if (ram_data_valid && !in_xfer) stray_err <= 1'b1;

            if (mb_fin) begin
                if (row_end) begin
                    mb_x <= 7'd0;
                    mb_y <= (mb_y == LAST_Y) ? 6'd0 : mb_y + 6'd1;
                end else begin
                    mb_x <= mb_x + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mb_read_ctrl.sv
// Bench for mb_read_ctrl: a transaction-level model checks every cycle on the full-size
// instance; a small instance walks a whole frame with directed expectations.
module tb_mb_read_ctrl;

    localparam int HMB   = 80;
    localparam int VMB   = 45;
    localparam int WORDS = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, ram_r_valid, ram_data_valid, enc_ready;
    logic       ram_r_ready, mb_start, mb_done, frame_done, busy, stray_err;
    logic [6:0] ram_r_addr, mb_x, word_idx;
    logic [5:0] mb_y;

    logic       s_enable, s_rrv, s_dv, s_enc;
    logic       s_ready, s_start, s_done, s_frame, s_busy, s_stray;
    logic [6:0] s_addr, s_x, s_widx;
    logic [5:0] s_y;

    mb_read_ctrl #(.HMB(HMB), .VMB(VMB), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ram_r_valid(ram_r_valid),
        .ram_data_valid(ram_data_valid), .enc_ready(enc_ready),
        .ram_r_ready(ram_r_ready), .ram_r_addr(ram_r_addr), .mb_start(mb_start),
        .mb_done(mb_done), .frame_done(frame_done), .mb_x(mb_x), .mb_y(mb_y),
        .word_idx(word_idx), .busy(busy), .stray_err(stray_err)
    );

    mb_read_ctrl #(.HMB(3), .VMB(2), .WORDS(4)) dut_small (
        .clk(clk), .rst(rst), .enable(s_enable), .ram_r_valid(s_rrv),
        .ram_data_valid(s_dv), .enc_ready(s_enc),
        .ram_r_ready(s_ready), .ram_r_addr(s_addr), .mb_start(s_start),
        .mb_done(s_done), .frame_done(s_frame), .mb_x(s_x), .mb_y(s_y),
        .word_idx(s_widx), .busy(s_busy), .stray_err(s_stray)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // RAM emulation: data returns exactly one cycle after each accepted read.
    bit force_dv = 1'b0;
    bit rdy_q    = 1'b0;
    bit s_rdy_q  = 1'b0;

    task automatic cyc();
        @(negedge clk);
        ram_data_valid = rdy_q | force_dv;
        rdy_q          = ram_r_ready;
        s_dv           = s_rdy_q;
        s_rdy_q        = s_ready;
    endtask

    function automatic bit pick(input int sel);
        case (sel)
            0:       return mb_start;
            1:       return mb_done;
            2:       return ram_r_ready && (ram_r_addr == 7'd40);
            3:       return ram_r_ready && (ram_r_addr == 7'd50);
            4:       return s_done;
            default: return ram_r_ready && (ram_r_addr == 7'd20);
        endcase
    endfunction

    task automatic wait_evt(input string name, input int sel, input int bound);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            cyc();
            hit = pick(sel);
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // Transaction model: address stream per macroblock, return count, grid position.
    int exp_addr = 0;
    int ret      = 0;
    int ex       = 0;
    int ey       = 0;
    int widx_e   = 0;
    bit in_mb    = 1'b0;
    bit stray_e  = 1'b0;
    bit need_low = 1'b0;

    always @(posedge clk) begin
        bit done_e;
        bit frame_e;
        #2;
        done_e  = 1'b0;
        frame_e = 1'b0;
        if (rst) begin
            exp_addr = 0; ret = 0; ex = 0; ey = 0; widx_e = 0;
            in_mb = 1'b0; stray_e = 1'b0; need_low = 1'b0;
            check("rst_ready", 32'(ram_r_ready), 32'd0);
            check("rst_addr", 32'(ram_r_addr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_pulses", 32'({mb_start, mb_done, frame_done}), 32'd0);
            check("rst_pos", 32'({mb_x, mb_y}), 32'd0);
            check("rst_widx", 32'(word_idx), 32'd0);
            check("rst_stray", 32'(stray_err), 32'd0);
        end else begin
            if (ram_data_valid) begin
                if (in_mb) begin
                    widx_e = ret;
                    ret++;
                    if (ret == WORDS) begin
                        done_e   = 1'b1;
                        in_mb    = 1'b0;
                        exp_addr = 0;
                        if (ex == HMB - 1) begin
                            ex       = 0;
                            need_low = 1'b1;
                            if (ey == VMB - 1) begin
                                ey      = 0;
                                frame_e = 1'b1;
                            end else begin
                                ey++;
                            end
                        end else begin
                            ex++;
                        end
                    end
                end else begin
                    stray_e = 1'b1;
                end
            end
            check("mb_done", 32'(mb_done), 32'(done_e));
            check("frame_done", 32'(frame_done), 32'(frame_e));
            check("mb_x", 32'(mb_x), ex);
            check("mb_y", 32'(mb_y), ey);
            check("word_idx", 32'(word_idx), widx_e);
            check("stray_err", 32'(stray_err), 32'(stray_e));

            if (ram_r_ready) begin
                check("mb_start", 32'(mb_start), 32'(exp_addr == 0));
                if (exp_addr == 0) begin
                    check("start_cond", 32'(enable && ram_r_valid && enc_ready && !need_low), 32'd1);
                    in_mb = 1'b1;
                    ret   = 0;
                end
                if (exp_addr >= WORDS) check("issue_overrun", exp_addr, WORDS - 1);
                check("ram_r_addr", 32'(ram_r_addr), exp_addr);
                exp_addr++;
            end else begin
                check("mb_start_idle", 32'(mb_start), 32'd0);
                check("ram_r_addr_idle", 32'(ram_r_addr), 32'd0);
                if (exp_addr > 0 && exp_addr < WORDS) check("issue_stall", exp_addr, WORDS);
            end
            if (!done_e && !ram_r_valid) need_low = 1'b0;
            if (in_mb) check("busy_in_mb", 32'(busy), 32'd1);
        end
    end

    int s_frames = 0;
    always @(posedge clk) begin
        #2;
        if (s_frame) s_frames++;
    end

    initial begin
        int n;
        int last;
        rst = 1'b1; enable = 1'b0; ram_r_valid = 1'b0; ram_data_valid = 1'b0; enc_ready = 1'b0;
        s_enable = 1'b0; s_rrv = 1'b0; s_dv = 1'b0; s_enc = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(ram_r_ready), 32'd0);
        check("idle_pos", 32'({mb_x, mb_y}), 32'd0);

        // Encoder not ready: buffer valid but nothing may be issued.
        enable = 1'b1; ram_r_valid = 1'b1; enc_ready = 1'b0;
        n = 0;
        repeat (10) begin cyc(); n += int'(ram_r_ready); end
        check("no_issue_wo_enc", n, 0);
        check("wait_buf_busy", 32'(busy), 32'd1);
        enc_ready = 1'b1;
        cyc();
        check("first_start", 32'(mb_start), 32'd1);
        check("first_addr", 32'(ram_r_addr), 32'd0);

        n = 0; last = -1;
        for (int i = 0; i < 200; i++) begin
            if (!ram_r_ready) break;
            n++;
            last = int'(ram_r_addr);
            cyc();
        end
        check("issue_len", n, 96);
        check("issue_last_addr", last, 95);
        wait_evt("first_done", 1, 5);
        check("first_done_x", 32'(mb_x), 32'd1);
        check("first_done_y", 32'(mb_y), 32'd0);
        check("first_done_widx", 32'(word_idx), 32'd95);

        // Finish the row; buffer flag stays high so the FSM must park until it drops.
        for (int k = 1; k < HMB; k++) wait_evt("row_done", 1, 120);
        check("row_end_x", 32'(mb_x), 32'd0);
        check("row_end_y", 32'(mb_y), 32'd1);
        n = 0;
        repeat (10) begin cyc(); n += int'(ram_r_ready); end
        check("wait_low_hold", n, 0);
        check("wait_low_busy", 32'(busy), 32'd1);
        ram_r_valid = 1'b0;
        cyc();
        ram_r_valid = 1'b1;
        wait_evt("start_after_low", 0, 5);

        // Disable mid-issue: the macroblock completes, then back to idle.
        wait_evt("addr40", 2, 100);
        enable = 1'b0;
        wait_evt("done_disabled", 1, 120);
        check("disabled_busy", 32'(busy), 32'd0);
        check("disabled_x", 32'(mb_x), 32'd1);
        n = 0;
        repeat (5) begin cyc(); n += int'(ram_r_ready) + int'(busy); end
        check("stays_idle", n, 0);

        // Stray return while idle is sticky.
        force_dv = 1'b1;
        cyc();
        force_dv = 1'b0;
        repeat (2) cyc();
        check("stray_set", 32'(stray_err), 32'd1);

        // Resume at the held position; buffer flag dropping mid-issue must not stall.
        enable = 1'b1;
        wait_evt("resume", 0, 5);
        check("resume_x", 32'(mb_x), 32'd1);
        check("resume_y", 32'(mb_y), 32'd1);
        wait_evt("addr20", 5, 30);
        ram_r_valid = 1'b0;
        repeat (4) cyc();
        ram_r_valid = 1'b1;

        // Reset in the middle of an issue burst.
        wait_evt("addr50", 3, 40);
        check("stray_sticky", 32'(stray_err), 32'd1);
        rst = 1'b1; enable = 1'b0;
        cyc();
        check("mid_rst_ready", 32'(ram_r_ready), 32'd0);
        check("mid_rst_addr", 32'(ram_r_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pos", 32'({mb_x, mb_y}), 32'd0);
        check("mid_rst_stray", 32'(stray_err), 32'd0);
        check("mid_rst_widx", 32'(word_idx), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Whole frame on a 3x2 grid of 4-word macroblocks.
        s_enable = 1'b1; s_rrv = 1'b1; s_enc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_evt("s_done", 4, 40);
            check("s_frame_done", 32'(s_frame), 32'(k == 6));
            check("s_x", 32'(s_x), k % 3);
            check("s_y", 32'(s_y), (k / 3) % 2);
            check("s_widx", 32'(s_widx), 32'd3);
            check("s_quiet", 32'({s_start, s_ready, s_addr}), 32'd0);
            if (k % 3 == 0) begin
                s_rrv = 1'b0;
                cyc();
                s_rrv = 1'b1;
            end
        end
        check("s_frame_count", s_frames, 1);
        check("s_busy", 32'(s_busy), 32'd1);
        check("s_stray", 32'(s_stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mb_read_ctrl.md
MB_READ_CTRL -- requirements
Module: mb_read_ctrl

Interface
REQ-001 SHALL have parameter HMB, default 80, macroblocks per buffer row (1280/16).
REQ-002 SHALL have parameter VMB, default 45, buffer rows per frame (720/16).
REQ-003 SHALL have parameter WORDS, default 96, 32-bit reads per macroblock (64 Y, then 32 UV).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  run request; sampled every cycle.
REQ-008 ram_r_valid  input  1  YUV RAM buffer-valid flag.
REQ-009 ram_data_valid  input  1  YUV RAM read-data-valid flag, one cycle after each accepted read.
REQ-010 enc_ready  input  1  encoder can accept a new macroblock.
REQ-011 ram_r_ready  output  1  read strobe to YUV RAM.
REQ-012 ram_r_addr  output  7  word index within macroblock, 0..WORDS-1.
REQ-013 mb_start  output  1  one-cycle pulse: macroblock issue begins.
REQ-014 mb_done  output  1  one-cycle pulse: last word of macroblock returned.
REQ-015 frame_done  output  1  one-cycle pulse, coincident with mb_done of last frame macroblock.
REQ-016 mb_x  output  7  current macroblock column, 0..HMB-1.
REQ-017 mb_y  output  6  current macroblock row, 0..VMB-1.
REQ-018 word_idx  output  7  index of word on ram_data_valid, 0..WORDS-1.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 stray_err  output  1  sticky: ram_data_valid seen outside ISSUE/DRAIN.

Function
REQ-021 SHALL implement states IDLE, WAIT_BUF, ISSUE, DRAIN, WAIT_LOW; all outputs registered except ram_r_ready/ram_r_addr (decoded from state and issue counter registers).
REQ-022 IDLE -> WAIT_BUF when enable=1.
REQ-023 WAIT_BUF: enable=0 -> IDLE; else ram_r_valid=1 and enc_ready=1 -> ISSUE, with mb_start asserted on the first ISSUE cycle.
REQ-024 ISSUE: ram_r_ready=1 every cycle; ram_r_addr = issue counter, 0 on first cycle, +1 per cycle; after addr WORDS-1 -> DRAIN; issue length exactly WORDS cycles, no stalls.
REQ-025 Return counter SHALL clear on ISSUE entry and increment on each ram_data_valid in ISSUE/DRAIN; word_idx = counter value before increment.
REQ-026 DRAIN: ram_r_ready=0; when return count reaches WORDS, pulse mb_done the same cycle the WORDS-th ram_data_valid is registered, then advance position.
REQ-027 Advance: mb_x<HMB-1 -> mb_x+1, next state WAIT_BUF (or IDLE if enable=0).
REQ-028 Advance: mb_x=HMB-1 -> mb_x=0; mb_y=VMB-1 -> mb_y=0 with frame_done pulse, else mb_y+1; next state WAIT_LOW.
REQ-029 WAIT_LOW: stay until ram_r_valid=0 observed for at least one cycle, then WAIT_BUF (or IDLE if enable=0); prevents re-reading the buffer just released.
REQ-030 enable deassert during ISSUE/DRAIN SHALL NOT abort; the macroblock completes, then the FSM goes to IDLE (via WAIT_LOW if row end).
REQ-031 ram_r_valid dropping during ISSUE SHALL NOT stall issue; behaviour unaffected.
REQ-032 ram_data_valid in IDLE/WAIT_BUF/WAIT_LOW SHALL be ignored for counting and set stray_err; stray_err clears only on rst.
REQ-033 ram_data_valid count beyond WORDS cannot occur in DRAIN exit cycle; any extra after exit sets stray_err.
REQ-034 mb_x/mb_y SHALL hold during IDLE; re-enable resumes at held position.

Reset
REQ-035 On rst=1 at a rising edge: state IDLE, counters 0, mb_x=0, mb_y=0, word_idx=0, ram_r_ready=0, ram_r_addr=0, all pulses 0, busy=0, stray_err=0; rst overrides any state including mid-ISSUE.

Verification
REQ-036 enable=1, ram_r_valid=1, enc_ready=1 -> mb_start, then 96 consecutive ram_r_ready cycles with addr 0..95, mb_done after 96th data_valid, mb_x=1.
REQ-037 enc_ready=0 held 10 cycles in WAIT_BUF -> no ram_r_ready; release -> issue starts next cycle.
REQ-038 Complete 80 macroblocks with ram_r_valid kept high -> after mb_x=79 done, mb_x=0, mb_y=1, FSM holds in WAIT_LOW until ram_r_valid low 1 cycle then high.
REQ-039 Run 80x45 macroblocks -> exactly one frame_done, coincident with final mb_done, mb_x=0, mb_y=0.
REQ-040 enable=0 at ISSUE addr 40 -> addresses continue to 95, mb_done, then busy=0 and IDLE.
REQ-041 ram_data_valid pulse in IDLE -> stray_err=1 and stays 1; rst mid-ISSUE (addr 50) -> all outputs at reset values next cycle.
